// File: rtl/adder_pkg.sv
// adder_pkg: default geometry and the per-stage pipeline record for pipelined_adder_nbit.
package adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  localparam int MAX_WIDTH = 256;
  typedef struct packed {
    logic valid;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic [MAX_WIDTH-1:0] sum;
    logic carry;
    logic ovf;
  } stage_t;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: W-bit combinational ripple of full-adder cells with a carry-into-MSB tap.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cmsb
);
  logic c;
  always_comb begin
    c = ci;
    cmsb = ci;
    s = '0;
    for (int i = 0; i < W; i++) begin
      cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit: WIDTH-bit adder cut into STAGES carry-pipelined slices with valid/ready flow control.
// Define PIPE_ADDER_SUB_EN to add the Sub port (A - B via ~B and carry-in 1).
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int SLICE = WIDTH / STAGES;
  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("pipelined_adder_nbit: illegal WIDTH/STAGES combination");
  end
  logic [WIDTH-1:0] bx;
  logic c0, stall, unused_last;
  stage_t head, last;
`ifdef PIPE_ADDER_SUB_EN
  assign bx = Sub ? ~B : B;
  assign c0 = Sub | Cin;
`else
  assign bx = B;
  assign c0 = Cin;
`endif
  assign stall = last.valid & ~out_ready;
  assign in_ready = ~stall;
  always_comb begin
    head = '0;
    head.valid = in_valid;
    head.a = MAX_WIDTH'(A);
    head.b = MAX_WIDTH'(bx);
    head.carry = c0;
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t src, nx, q;
    logic [SLICE-1:0] s;
    logic co, cm;
    if (k == 0) begin : g_head
      assign src = head;
    end else begin : g_link
      assign src = g_stage[k-1].q;
    end
    adder_slice #(.W(SLICE)) u_slice (
      .a   (src.a[k*SLICE +: SLICE]),
      .b   (src.b[k*SLICE +: SLICE]),
      .ci  (src.carry),
      .s   (s),
      .co  (co),
      .cmsb(cm)
    );
    // Only the last stage's ovf is observed; earlier ones are overwritten downstream.
    always_comb begin
      nx = src;
      nx.sum[k*SLICE +: SLICE] = s;
      nx.carry = co;
      nx.ovf = co ^ cm;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else if (!stall) q <= nx;
    end
  end
  assign last = g_stage[STAGES-1].q;
  assign out_valid = last.valid;
  assign Sum = last.sum[WIDTH-1:0];
  assign Cout = last.carry;
  assign Ovf = last.ovf;
  assign unused_last = ^{last.a, last.b, last.sum};
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// tb_pipelined_adder_nbit: directed and randomized checks of pipelined_adder_nbit against an arithmetic queue model.
module tb_pipelined_adder_nbit;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout, ovf, sb;
  logic [W-1:0] a = '0, b = '0, sum;
  logic [W+1:0] q[$];
  logic [W+1:0] held;
  logic hold = 0;
  int checks = 0, failures = 0;
`ifdef PIPE_ADDER_SUB_EN
  logic sub = 0;
  assign sb = sub;
`else
  assign sb = 1'b0;
`endif
  always #5 clk = ~clk;
  pipelined_adder_nbit #(.WIDTH(W), .STAGES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin),
`ifdef PIPE_ADDER_SUB_EN
    .Sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .Cout(cout), .Ovf(ovf)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // {ovf, cout, sum} from plain unsigned/signed integer arithmetic
  function automatic logic [W+1:0] model(logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
    longint ux, uy, sx, sy, r, sr;
    logic co;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r = ux - uy;
      sr = sx - sy;
      co = ux >= uy;
    end else begin
      r = ux + uy + longint'(c);
      sr = sx + sy + longint'(c);
      co = r >= (longint'(1) << W);
    end
    return {(sr > 32767 || sr < -32768), co, r[W-1:0]};
  endfunction
  always @(negedge clk) begin
    if (rst) hold = 0;
    else begin
      if (hold) check("hold", {out_valid, ovf, cout, sum}, {1'b1, held});
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (q.size() == 0) check("spurious", out_valid, 0);
        else if (out_ready) check("result", {ovf, cout, sum}, q.pop_front());
      end
      hold = out_valid && !out_ready;
      held = {ovf, cout, sum};
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sb));
    end
  end
  task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic c);
    logic ok;
    int n = 0;
    in_valid = 1; a = x; b = y; cin = c;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check("issue_timeout", 0, 1);
  endtask
  task automatic wait_out();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) check("wait_out_timeout", 0, 1);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ready", in_ready, 1);
    rst = 0;
    issue(16'hFFFF, 16'h0001, 0);
    in_valid = 0;
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      check("lat_early", out_valid, 0);
    end
    @(negedge clk);
    check("lat", out_valid, 1);
    check("carry_sum", sum, 16'h0000);
    check("carry_cout", cout, 1);
    check("carry_ovf", ovf, 0);
    @(posedge clk); #1;
    issue(16'h7FFF, 16'h0001, 0);
    issue(16'h1234, 16'h4321, 1);
    in_valid = 0;
    wait_out();
    check("ovf_sum", sum, 16'h8000);
    check("ovf_cout", cout, 0);
    check("ovf_ovf", ovf, 1);
    @(negedge clk);
    check("cin_sum", sum, 16'h5556);
    check("cin_valid", out_valid, 1);
    drain();
    for (int i = 0; i < 3; i++) issue(W'($urandom), W'($urandom), 1'($urandom));
    in_valid = 0;
    wait_out();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stream_gap", out_valid, 1);
    end
    @(negedge clk);
    check("stream_end", out_valid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) issue(W'($urandom), W'($urandom), 1'($urandom));
    check("bp_full", out_valid, 1);
    out_ready = 0;
    a = 16'hAAAA; b = 16'h5555;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    drain();
    for (int i = 0; i < 3; i++) issue(W'($urandom), W'($urandom), 1'($urandom));
    in_valid = 0;
    @(posedge clk); #1;
    check("pre_rst_valid", out_valid, 1);
    rst = 1;
    q.delete();
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_sum", sum, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    issue(16'h00FF, 16'h0F01, 0);
    issue(16'h8000, 16'h8000, 1);
    in_valid = 0;
    drain();
`ifdef PIPE_ADDER_SUB_EN
    sub = 1;
    issue(16'h0005, 16'h0007, 0);
    issue(16'h8000, 16'h0001, 1);
    in_valid = 0;
    sub = 0;
    wait_out();
    check("sub_sum", sum, 16'hFFFE);
    check("sub_cout", cout, 0);
    @(negedge clk);
    check("subovf_sum", sum, 16'h7FFF);
    check("subovf_ovf", ovf, 1);
    drain();
`endif
    repeat (400) begin
      in_valid = $urandom_range(0, 3) != 0;
      a = ($urandom_range(0, 4) == 0) ? 16'hFFFF : W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? 16'h8000 : W'($urandom);
      cin = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

Parametrised N-bit adder that splits the carry chain into `STAGES` equal slices and places one register stage per slice. The carry hops between slices through pipeline registers, so Fmax depends on slice width rather than on `WIDTH`. The block carries a valid/ready handshake with full back-pressure and sits in the datapath wherever a wide add must close timing at the system clock. It is the parametrised, pipelined successor to the team's fixed 4-bit ripple adder.

## Interface
- `WIDTH`, 16: operand and sum width in bits; ≥ 1.
- `STAGES`, 4: number of pipeline stages (slices); 1 ≤ `STAGES` ≤ `WIDTH`; `WIDTH % STAGES == 0`, otherwise elaboration fails.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block accepts operands this cycle.
- `A`  in  `WIDTH`  operand A.
- `B`  in  `WIDTH`  operand B.
- `Cin`  in  1  carry-in.
- `Sub`  in  1  subtract select; present only with `PIPE_ADDER_SUB_EN`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `Sum`  out  `WIDTH`  result.
- `Cout`  out  1  carry-out of the MSB.
- `Ovf`  out  1  two's-complement overflow.

## Operation
- Slice width is `SLICE = WIDTH/STAGES`. Stage k adds bits [k·SLICE +: SLICE] using the carry registered by stage k-1. Stage 0 uses the transaction's `Cin`.
- Skew: operand bits above slice k travel forward in stage registers. Deskew: completed lower sum bits travel forward alongside them. The final stage outputs all `WIDTH` sum bits aligned.
- `Cout` is the carry out of the MSB slice.
- `Ovf` = carry into the MSB XOR carry out of the MSB, computed in the final stage.
- Arithmetic is modulo 2^`WIDTH`. Results are exact for every input: no saturation.
- Each stage holds a valid bit. Bubbles propagate and do not corrupt data.
- Global stall: `stall = out_valid & ~out_ready`. On stall, no register updates and all outputs hold stable.
- `in_ready = ~stall`, combinational. A transfer occurs when `in_valid & in_ready`. An input with `in_valid` low while not stalled inserts a bubble.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.
- No state machine beyond the per-stage valid bits. Transactions emerge strictly in issue order.

## Timing
- Reset: all valid bits, data registers, `out_valid`, `Sum`, `Cout` and `Ovf` are 0. `in_ready` is 1.
- Reset mid-stream discards every in-flight transaction. The first cycle after release shows `out_valid = 0`, and no stale result ever appears.
- Latency is `STAGES` cycles from an accepting edge to `out_valid` high. `STAGES = 1` gives a single registered adder with latency 1.
- Throughput is 1 result per cycle when `out_ready` is held high.
- `Sum`, `Cout` and `Ovf` are registered outputs, valid only while `out_valid` is high. They must not change while `out_valid & ~out_ready`.
- Critical path is one `SLICE`-bit ripple plus register setup.

## Configuration
- `PIPE_ADDER_SUB_EN` defined:
  - The `Sub` port exists and is captured with the operands.
  - When `Sub = 1`, stage 0 uses `~B` and carry-in 1, so the result is A − B. `Cin` is ignored in this case.
  - `Cout = 1` means no borrow. `Ovf` is signed subtraction overflow.
- `PIPE_ADDER_SUB_EN` undefined: no `Sub` port, no inversion logic, add only.

## Structure
- Package `adder_pkg`:
  - Default `WIDTH` and `STAGES` constants.
  - A typedef for the per-stage record: valid, remaining A/B bits, partial sum, carry.
- One sub-module, `adder_slice`: a `SLICE`-bit combinational ripple of 1-bit full-adder cells. It has carry-in and carry-out, and a carry-into-MSB tap for `Ovf`.
- The top generates `STAGES` slices plus the stage registers and handshake.

## Test plan
All scenarios use `WIDTH = 16`, `STAGES = 4`.
- Full carry propagation: 0xFFFF + 0x0001, `Cin = 0` → exactly 4 cycles later `Sum = 0x0000`, `Cout = 1`, `Ovf = 0`.
- Signed overflow: 0x7FFF + 0x0001 → `Sum = 0x8000`, `Cout = 0`, `Ovf = 1`. Also 0x1234 + 0x4321, `Cin = 1` → `Sum = 0x5556`.
- Back-to-back stream: 3 transactions on consecutive cycles with `out_ready = 1` → 3 results on consecutive cycles, in order, no gaps.
- Back-pressure: fill the pipe with 4 transactions, then drop `out_ready` for 3 cycles → `in_ready = 0` and outputs frozen. After release the remaining results drain in order, with no loss and no duplication.
- Reset mid-stream: assert `rst` with 3 transactions in flight → `out_valid` goes 0 immediately. After release, only post-reset transactions appear.
- With `PIPE_ADDER_SUB_EN`: 0x0005 − 0x0007 → `Sum = 0xFFFE`, `Cout = 0`. Also 0x8000 − 0x0001 → `Sum = 0x7FFF`, `Ovf = 1`.
